// File: rtl/me_pkg.sv
// Shared types and default geometry for the motion-estimation search sequencer.
// Window width and candidate count are derived from block edge and search range.
package me_pkg;

  localparam int unsigned EDGE_LEN     = 8;
  localparam int unsigned BIT_DEPTH    = 8;
  localparam int unsigned SEARCH_RANGE = 8;
  localparam int unsigned WIN_COLS     = 2*SEARCH_RANGE + EDGE_LEN - 1;
  localparam int unsigned NUM_CAND     = WIN_COLS - EDGE_LEN + 1;
  localparam int unsigned AD_LATENCY   = 2;
  localparam int unsigned ADDR_W       = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CUR,
    SCAN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/me_valid_pipe.sv
// Valid + tag shift register that tracks batches through a fixed-latency pipeline.
// Advances only on en_i; clr_i empties it synchronously.
module me_valid_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  logic [DEPTH-1:0] vld;
  logic [TAG_W-1:0] tag [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) tag[i] <= '0;
    end else if (en_i) begin
      vld[0] <= valid_i;
      tag[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
      end
    end
  end

  assign valid_o = vld[DEPTH-1];
  assign tag_o   = tag[DEPTH-1];
  assign busy_o  = |vld;

endmodule

// File: rtl/me_search_ctrl.sv
// Sequencer for the ME column datapath: block load, window scan, batch tagging.
// Define ME_SEARCH_ABORT_EN to add the abort_i / abort_ack_o search cancel.
module me_search_ctrl #(
  parameter int unsigned EDGE_LEN   = 8,
  parameter int unsigned WIN_COLS   = 23,
  parameter int unsigned AD_LATENCY = 2,
  parameter int unsigned ADDR_W     = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              acc_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              cur_rd_en_o,
  output logic [ADDR_W-1:0] cur_row_o,
  output logic              cur_we_o,
  output logic              ref_rd_en_o,
  output logic [ADDR_W-1:0] ref_col_o,
  output logic              fifo_shift_o,
  output logic              pipe_en_o,
  output logic              psad_valid_o,
  output logic [ADDR_W-1:0] cand_x_o
`ifdef ME_SEARCH_ABORT_EN
  ,
  input  logic              abort_i,
  output logic              abort_ack_o
`endif
);

  import me_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ROW   = ADDR_W'(EDGE_LEN);
  localparam logic [ADDR_W-1:0] LAST_COL   = ADDR_W'(WIN_COLS - 1);
  localparam logic [ADDR_W-1:0] FIRST_CAND = ADDR_W'(EDGE_LEN - 1);

  state_e            state;
  state_e            state_nxt;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] shift_col;
  logic              cur_we;
  logic              shift_pend;
  logic              pipe_en;
  logic              abort;
  logic              pipe_busy;
  logic              vin;
  logic [ADDR_W-1:0] vtag;

`ifdef ME_SEARCH_ABORT_EN
  assign abort = abort_i && (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) abort_ack_o <= 1'b0;
    else          abort_ack_o <= abort;
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (start_i) state_nxt = LOAD_CUR;
      LOAD_CUR: if (row == LAST_ROW) state_nxt = SCAN;
      SCAN:     if (pipe_en && col == LAST_COL) state_nxt = DRAIN;
      DRAIN:    if (!shift_pend && !pipe_busy) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_comb begin
    pipe_en     = 1'b1;
    cur_rd_en_o = 1'b0;
    ref_rd_en_o = 1'b0;
    done_o      = 1'b0;
    busy_o      = 1'b1;
    unique case (state)
      IDLE:     busy_o = 1'b0;
      LOAD_CUR: cur_rd_en_o = (row < LAST_ROW);
      SCAN: begin
        pipe_en     = acc_ready_i;
        ref_rd_en_o = acc_ready_i;
      end
      DRAIN:    pipe_en = acc_ready_i;
      DONE:     done_o = 1'b1;
      default:  busy_o = 1'b0;
    endcase
  end

  // shift_pend mirrors the held memory output: it only moves on enabled cycles
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || abort) begin
      row        <= '0;
      col        <= '0;
      cur_we     <= 1'b0;
      shift_pend <= 1'b0;
      shift_col  <= '0;
    end else begin
      cur_we <= cur_rd_en_o;
      if (state == LOAD_CUR && row < LAST_ROW) row <= row + 1'b1;
      else                                     row <= '0;
      if (pipe_en) begin
        shift_pend <= ref_rd_en_o;
        shift_col  <= col;
        if (ref_rd_en_o) col <= (col == LAST_COL) ? '0 : col + 1'b1;
      end
    end
  end

  assign vin  = shift_pend && pipe_en && (shift_col >= FIRST_CAND);
  assign vtag = shift_col - FIRST_CAND;

  me_valid_pipe #(
    .DEPTH (AD_LATENCY),
    .TAG_W (ADDR_W)
  ) u_vpipe (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (pipe_en),
    .clr_i   (abort),
    .valid_i (vin),
    .tag_i   (vtag),
    .valid_o (psad_valid_o),
    .tag_o   (cand_x_o),
    .busy_o  (pipe_busy)
  );

  assign cur_row_o    = row;
  assign cur_we_o     = cur_we;
  assign ref_col_o    = col;
  assign fifo_shift_o = shift_pend && pipe_en;
  assign pipe_en_o    = pipe_en;

endmodule

// File: tb/tb_me_search_ctrl.sv
// Scoreboard bench for me_search_ctrl: expected tags queued at start, popped on consume.
// Abort scenario is built only when ME_SEARCH_ABORT_EN is defined.
module tb_me_search_ctrl;

  localparam int NUM_CAND = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       acc_ready = 1'b1;
  logic       busy, done, cur_rd_en, cur_we, ref_rd_en;
  logic       fifo_shift, pipe_en, psad_valid;
  logic [4:0] cur_row, ref_col, cand_x;
`ifdef ME_SEARCH_ABORT_EN
  logic       abort = 1'b0;
  logic       abort_ack;
`endif

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int batch_cnt = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  me_search_ctrl dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .acc_ready_i  (acc_ready),
    .busy_o       (busy),
    .done_o       (done),
    .cur_rd_en_o  (cur_rd_en),
    .cur_row_o    (cur_row),
    .cur_we_o     (cur_we),
    .ref_rd_en_o  (ref_rd_en),
    .ref_col_o    (ref_col),
    .fifo_shift_o (fifo_shift),
    .pipe_en_o    (pipe_en),
    .psad_valid_o (psad_valid),
    .cand_x_o     (cand_x)
`ifdef ME_SEARCH_ABORT_EN
    ,
    .abort_i      (abort),
    .abort_ack_o  (abort_ack)
`endif
  );

  task automatic monitor();
    int e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (psad_valid === 1'b1 && acc_ready === 1'b1) begin
        batch_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_extra_batch cand_x=%0d required=no batch", cand_x);
        end else begin
          e = exp_q.pop_front();
          if (cand_x !== 5'(e)) begin
            failures++;
            $display("FAIL sb_cand_x got=%0d required=%0d", cand_x, e);
          end
        end
      end
    end
  endtask

  task automatic push_search();
    exp_q.delete();
    for (int i = 0; i < NUM_CAND; i++) exp_q.push_back(i);
    done_cnt = 0;
    batch_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [22:0] got;
    logic [22:0] req;
    rst_n = 1'b0;
    start = 1'b0;
    acc_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    got = {busy, done, cur_rd_en, cur_we, ref_rd_en, fifo_shift,
           psad_valid, cur_row, ref_col, cand_x, pipe_en};
    req = 23'h1;
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=%h", got, req);
    end
    step();
  endtask

  task automatic test_nominal(input bit extra_starts);
    logic e_cur, e_ref;
    logic [4:0] got, req;
    push_search();
    for (int n = 0; n < 45; n++) begin
      start = (n == 0) || (extra_starts && (n == 15 || n == 37));
      acc_ready = 1'b1;
      @(negedge clk);
      e_cur = (n >= 1 && n <= 8);
      e_ref = (n >= 10 && n <= 32);
      checks++;
      if (cur_rd_en !== e_cur || (e_cur && cur_row !== 5'(n - 1))) begin
        failures++;
        $display("FAIL nom_cur n=%0d rd=%b row=%0d required rd=%b row=%0d",
                 n, cur_rd_en, cur_row, e_cur, n - 1);
      end
      checks++;
      if (ref_rd_en !== e_ref || (e_ref && ref_col !== 5'(n - 10))) begin
        failures++;
        $display("FAIL nom_ref n=%0d rd=%b col=%0d required rd=%b col=%0d",
                 n, ref_rd_en, ref_col, e_ref, n - 10);
      end
      got = {cur_we, fifo_shift, psad_valid, done, busy};
      req = {(n >= 2 && n <= 9), (n >= 11 && n <= 33), (n >= 20 && n <= 35),
             (n == 37), (n >= 1 && n <= 37)};
      checks++;
      if (got !== req) begin
        failures++;
        $display("FAIL nom_ctrl n=%0d we/sh/pv/done/busy got=%b required=%b",
                 n, got, req);
      end
      step();
    end
    start = 1'b0;
    checks++;
    if (batch_cnt !== NUM_CAND || exp_q.size() !== 0 || done_cnt !== 1) begin
      failures++;
      $display("FAIL nom_totals batches=%0d left=%0d dones=%0d required 16/0/1",
               batch_cnt, exp_q.size(), done_cnt);
    end
  endtask

  task automatic test_stall();
    logic stall;
    push_search();
    for (int n = 0; n < 50; n++) begin
      stall = (n >= 27 && n <= 31);
      start = (n == 0);
      acc_ready = !stall;
      @(negedge clk);
      if (stall) begin
        checks++;
        if (psad_valid !== 1'b1 || cand_x !== 5'd7 || fifo_shift !== 1'b0 ||
            ref_rd_en !== 1'b0 || ref_col !== 5'd17 || pipe_en !== 1'b0) begin
          failures++;
          $display("FAIL stall_hold n=%0d pv=%b cand=%0d sh=%b rd=%b col=%0d en=%b required 1/7/0/0/17/0",
                   n, psad_valid, cand_x, fifo_shift, ref_rd_en, ref_col, pipe_en);
        end
      end
      if (n == 33) begin
        checks++;
        if (psad_valid !== 1'b1 || cand_x !== 5'd8) begin
          failures++;
          $display("FAIL stall_resume pv=%b cand=%0d required 1/8", psad_valid, cand_x);
        end
      end
      checks++;
      if (done !== (n == 42)) begin
        failures++;
        $display("FAIL stall_done n=%0d got=%b required=%b", n, done, (n == 42));
      end
      step();
    end
    acc_ready = 1'b1;
    checks++;
    if (batch_cnt !== NUM_CAND || exp_q.size() !== 0 || done_cnt !== 1) begin
      failures++;
      $display("FAIL stall_totals batches=%0d left=%0d dones=%0d required 16/0/1",
               batch_cnt, exp_q.size(), done_cnt);
    end
  endtask

  task automatic test_start_ignored();
    test_nominal(1'b1);
  endtask

  task automatic test_reset_mid();
    logic [22:0] got;
    push_search();
    for (int n = 0; n < 45; n++) begin
      start = (n == 0);
      acc_ready = 1'b1;
      rst_n = (n != 23);
      @(negedge clk);
      if (n == 23) begin
        checks++;
        if (psad_valid !== 1'b1 || cand_x !== 5'd3) begin
          failures++;
          $display("FAIL rmid_pre pv=%b cand=%0d required 1/3", psad_valid, cand_x);
        end
      end
      if (n == 24) begin
        got = {busy, done, cur_rd_en, cur_we, ref_rd_en, fifo_shift,
               psad_valid, cur_row, ref_col, cand_x, pipe_en};
        checks++;
        if (got !== 23'h1) begin
          failures++;
          $display("FAIL rmid_outputs got=%h required=%h", got, 23'h1);
        end
        exp_q.delete();
      end
      step();
    end
    rst_n = 1'b1;
    checks++;
    if (done_cnt !== 0 || batch_cnt !== 4) begin
      failures++;
      $display("FAIL rmid_totals dones=%0d batches=%0d required 0/4",
               done_cnt, batch_cnt);
    end
    test_nominal(1'b0);
  endtask

`ifdef ME_SEARCH_ABORT_EN
  task automatic test_abort();
    push_search();
    for (int n = 0; n < 45; n++) begin
      start = (n == 0);
      abort = (n == 34);
      acc_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (abort_ack !== (n == 35)) begin
        failures++;
        $display("FAIL abort_ack n=%0d got=%b required=%b", n, abort_ack, (n == 35));
      end
      if (n == 35) begin
        checks++;
        if (psad_valid !== 1'b0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL abort_state pv=%b busy=%b required 0/0", psad_valid, busy);
        end
        exp_q.delete();
      end
      step();
    end
    abort = 1'b0;
    checks++;
    if (done_cnt !== 0 || batch_cnt !== 15) begin
      failures++;
      $display("FAIL abort_totals dones=%0d batches=%0d required 0/15",
               done_cnt, batch_cnt);
    end
  endtask
`endif

  task automatic test_random();
    bit seen;
    for (int s = 0; s < 100; s++) begin
      push_search();
      start = 1'b1;
      acc_ready = 1'($urandom_range(0, 1));
      seen = 1'b0;
      for (int n = 0; n < 400 && !seen; n++) begin
        @(negedge clk);
        if (done === 1'b1) seen = 1'b1;
        step();
        start = 1'b0;
        acc_ready = 1'($urandom_range(0, 1));
      end
      checks++;
      if (!seen) begin
        failures++;
        $display("FAIL rand_timeout search=%0d got=no done required=done", s);
      end
      checks++;
      if (batch_cnt !== NUM_CAND || exp_q.size() !== 0 || done_cnt !== 1) begin
        failures++;
        $display("FAIL rand_totals search=%0d batches=%0d left=%0d dones=%0d required 16/0/1",
                 s, batch_cnt, exp_q.size(), done_cnt);
      end
      exp_q.delete();
    end
    acc_ready = 1'b1;
    step();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_nominal(1'b0);
    test_stall();
    test_start_ignored();
    test_reset_mid();
`ifdef ME_SEARCH_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
